// File: rtl/tag_record_src.sv
// Record FIFO plus MSB-first byte serialiser that requests the host output mux one whole record at a time.
// Records arriving while the FIFO is full are dropped and counted in a saturating loss counter.
module tag_record_src #(
    parameter int REC_BYTES  = 6,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [8*REC_BYTES-1:0] rec_i,
    input  logic                   rec_wr_i,
    output logic                   rec_full_o,
    output logic [DEPTH_LOG2:0]    fill_o,
    output logic [15:0]            lost_o,
    input  logic                   lost_clr_i,
    output logic                   omux_req_o,
    input  logic                   omux_sel_i,
    output logic [7:0]             omux_data_o
);

    localparam int REC_W = 8 * REC_BYTES;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int IDX_W = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(REC_BYTES - 1);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    logic [REC_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [15:0]           lost;

    state_t                state;
    state_t                state_nxt;
    logic [REC_W-1:0]      hold;
    logic [REC_W-1:0]      hold_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [REC_W-1:0]      hold_shifted;

    logic                  full;
    logic                  push;
    logic                  drop;
    logic                  pop;

    // Full is judged on the count at the start of the cycle; a same-cycle pop does not make room.
    assign full = (count == FULL_COUNT);
    assign push = rec_wr_i && !full;
    assign drop = rec_wr_i && full;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = idx;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    hold_nxt  = mem[rd_ptr];
                    idx_nxt   = '0;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (omux_sel_i) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state <= S_IDLE;
            hold  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= rec_i;
    end

    // A clear in the same cycle as a drop counts that drop, so nothing is silently lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lost <= '0;
        end else if (lost_clr_i) begin
            lost <= drop ? 16'd1 : 16'd0;
        end else if (drop && (lost != 16'hFFFF)) begin
            lost <= lost + 16'd1;
        end
    end

    assign hold_shifted = hold << {idx, 3'b000};

    assign fill_o      = count;
    assign rec_full_o  = full;
    assign lost_o      = lost;
    assign omux_req_o  = (state == S_SEND);
    assign omux_data_o = hold_shifted[REC_W-1 -: 8];

endmodule

// File: tb/tb_tag_record_src.sv
// Self-checking bench for tag_record_src: directed scenarios plus a randomized run against a queue-based model.
module tb_tag_record_src;

    localparam int REC_BYTES  = 6;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] rec;
    logic        rec_wr;
    logic        rec_full_o;
    logic [4:0]  fill_o;
    logic [15:0] lost_o;
    logic        lost_clr;
    logic        omux_req_o;
    logic        sel;
    logic [7:0]  omux_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the randomized run.
    logic [47:0] m_q[$];
    bit          m_busy;
    logic [47:0] m_hold;
    int          m_idx;
    int          m_lost;

    always #5 clk = ~clk;

    tag_record_src #(.REC_BYTES(REC_BYTES), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .rec_i      (rec),
        .rec_wr_i   (rec_wr),
        .rec_full_o (rec_full_o),
        .fill_o     (fill_o),
        .lost_o     (lost_o),
        .lost_clr_i (lost_clr),
        .omux_req_o (omux_req_o),
        .omux_sel_i (sel),
        .omux_data_o(omux_data_o)
    );

    function automatic logic [7:0] byte_of(input logic [47:0] r, input int k);
        return r[47-8*k -: 8];
    endfunction

    function automatic logic [47:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A, b + 8'd1, 8'hC3, b * 8'd7};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        reset = 1'b0;
    endtask

    task automatic write_rec(input logic [47:0] r);
        rec    = r;
        rec_wr = 1'b1;
        step;
        rec_wr = 1'b0;
    endtask

    // Mux model: waits for a request, takes the current byte with a one-cycle grant, then idles for gap cycles.
    task automatic grab_byte(input int gap, output logic [7:0] b, output bit ok);
        int t = 0;
        while (omux_req_o !== 1'b1 && t < 100) begin
            step;
            t++;
        end
        ok = (omux_req_o === 1'b1);
        b  = omux_data_o;
        if (ok) begin
            sel = 1'b1;
            step;
            sel = 1'b0;
            repeat (gap) step;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) step;
        n_checks++;
        if (omux_req_o !== 1'b0 || omux_data_o !== 8'h00 || rec_full_o !== 1'b0 || fill_o !== 5'd0 || lost_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: req=%b data=%h full=%b fill=%0d lost=%0d, expected all zero",
                     omux_req_o, omux_data_o, rec_full_o, fill_o, lost_o);
        end
        reset = 1'b0;
        step;
        n_checks++;
        if (omux_req_o !== 1'b0 || fill_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: req=%b fill=%0d, expected req=0 fill=0", omux_req_o, fill_o);
        end
    endtask

    task automatic test_single_record;
        logic [47:0] r = 48'h0A0B0C0D0E0F;
        logic [7:0]  b;
        bit          ok;
        do_reset;
        write_rec(r);
        n_checks++;
        if (omux_req_o !== 1'b0 || fill_o !== 5'd1) begin
            n_fail++;
            $display("FAIL single_after_strobe: req=%b fill=%0d, expected req=0 fill=1", omux_req_o, fill_o);
        end
        step;
        n_checks++;
        if (omux_req_o !== 1'b1 || fill_o !== 5'd0) begin
            n_fail++;
            $display("FAIL single_request: req=%b fill=%0d, expected req=1 fill=0", omux_req_o, fill_o);
        end
        for (int k = 0; k < REC_BYTES; k++) begin
            grab_byte((k == REC_BYTES - 1) ? 0 : 3, b, ok);
            n_checks++;
            if (!ok || b !== byte_of(r, k)) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h (req seen %0b), expected %h", k, b, ok, byte_of(r, k));
            end
        end
        n_checks++;
        if (omux_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req_drop: req=%b, expected 0", omux_req_o);
        end
    endtask

    task automatic test_sel_stall;
        logic [47:0] r = 48'h0A0B0C0D0E0F;
        logic [7:0]  b;
        bit          ok;
        do_reset;
        write_rec(r);
        for (int k = 0; k < 3; k++) begin
            grab_byte(0, b, ok);
            n_checks++;
            if (!ok || b !== byte_of(r, k)) begin
                n_fail++;
                $display("FAIL stall_pre_byte%0d: got %h, expected %h", k, b, byte_of(r, k));
            end
        end
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (omux_req_o !== 1'b1 || omux_data_o !== 8'h0D) begin
                n_fail++;
                $display("FAIL stall_hold_c%0d: req=%b data=%h, expected req=1 data=0d", c, omux_req_o, omux_data_o);
            end
            step;
        end
        for (int k = 3; k < REC_BYTES; k++) begin
            grab_byte(2, b, ok);
            n_checks++;
            if (!ok || b !== byte_of(r, k)) begin
                n_fail++;
                $display("FAIL stall_post_byte%0d: got %h, expected %h", k, b, byte_of(r, k));
            end
        end
        n_checks++;
        if (omux_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: req=%b, expected 0", omux_req_o);
        end
    endtask

    task automatic test_full_overflow;
        logic [7:0] b;
        bit         ok;
        do_reset;
        rec_wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rec = pat(i);
            step;
        end
        for (int i = 0; i < 3; i++) begin
            rec = 48'hDEADBEEF0000 | 48'(i);
            step;
        end
        rec_wr = 1'b0;
        n_checks++;
        if (fill_o !== 5'd16 || rec_full_o !== 1'b1 || lost_o !== 16'd3 || omux_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: fill=%0d full=%b lost=%0d req=%b, expected 16 1 3 1",
                     fill_o, rec_full_o, lost_o, omux_req_o);
        end
        for (int n = 0; n < 17; n++) begin
            for (int k = 0; k < REC_BYTES; k++) begin
                grab_byte(0, b, ok);
                n_checks++;
                if (!ok || b !== byte_of(pat(n), k)) begin
                    n_fail++;
                    $display("FAIL drain_rec%0d_byte%0d: got %h, expected %h", n, k, b, byte_of(pat(n), k));
                end
            end
            n_checks++;
            if (omux_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_gap_rec%0d: req=%b, expected 0", n, omux_req_o);
            end
            if (n < 16) begin
                step;
                n_checks++;
                if (omux_req_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drain_rereq_rec%0d: req=%b, expected 1", n, omux_req_o);
                end
            end
        end
        n_checks++;
        if (fill_o !== 5'd0 || rec_full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: fill=%0d full=%b, expected 0 0", fill_o, rec_full_o);
        end
    endtask

    task automatic test_lost_counter;
        do_reset;
        rec_wr = 1'b1;
        rec    = 48'h123456789ABC;
        repeat (22) step;
        n_checks++;
        if (lost_o !== 16'd5) begin
            n_fail++;
            $display("FAIL lost_five: lost=%0d, expected 5", lost_o);
        end
        lost_clr = 1'b1;
        step;
        lost_clr = 1'b0;
        n_checks++;
        if (lost_o !== 16'd1) begin
            n_fail++;
            $display("FAIL lost_clr_with_drop: lost=%0d, expected 1", lost_o);
        end
        rec_wr   = 1'b0;
        lost_clr = 1'b1;
        step;
        lost_clr = 1'b0;
        n_checks++;
        if (lost_o !== 16'd0) begin
            n_fail++;
            $display("FAIL lost_clr_alone: lost=%0d, expected 0", lost_o);
        end
        rec_wr = 1'b1;
        repeat (65535) step;
        n_checks++;
        if (lost_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL lost_reach_max: lost=%h, expected ffff", lost_o);
        end
        step;
        rec_wr = 1'b0;
        n_checks++;
        if (lost_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL lost_saturate: lost=%h, expected ffff", lost_o);
        end
    endtask

    task automatic test_reset_mid_record;
        logic [7:0] b;
        bit         ok;
        do_reset;
        rec_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rec = pat(100 + i);
            step;
        end
        rec_wr = 1'b0;
        n_checks++;
        if (fill_o !== 5'd2) begin
            n_fail++;
            $display("FAIL midreset_queued: fill=%0d, expected 2", fill_o);
        end
        for (int k = 0; k < 3; k++) begin
            grab_byte(0, b, ok);
            n_checks++;
            if (!ok || b !== byte_of(pat(100), k)) begin
                n_fail++;
                $display("FAIL midreset_pre_byte%0d: got %h, expected %h", k, b, byte_of(pat(100), k));
            end
        end
        do_reset;
        n_checks++;
        if (omux_req_o !== 1'b0 || fill_o !== 5'd0 || omux_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_after: req=%b fill=%0d data=%h, expected 0 0 00", omux_req_o, fill_o, omux_data_o);
        end
        write_rec(pat(200));
        for (int k = 0; k < REC_BYTES; k++) begin
            grab_byte(1, b, ok);
            n_checks++;
            if (!ok || b !== byte_of(pat(200), k)) begin
                n_fail++;
                $display("FAIL midreset_new_byte%0d: got %h, expected %h", k, b, byte_of(pat(200), k));
            end
        end
        n_checks++;
        if (omux_req_o !== 1'b0 || fill_o !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_idle: req=%b fill=%0d, expected 0 0", omux_req_o, fill_o);
        end
    endtask

    task automatic test_random;
        int          gap = 0;
        int          n_wr = 0;
        int          n_acc = 0;
        int          n_rx = 0;
        int          rx_n = 0;
        int          fail0;
        int          start_size;
        bit          feeding;
        bit          wr;
        bit          s;
        logic [47:0] rx = '0;
        logic [47:0] r;
        logic [63:0] t64;
        do_reset;
        m_q.delete();
        m_busy = 1'b0;
        m_hold = '0;
        m_idx  = 0;
        m_lost = 0;
        fail0  = n_fail;
        for (int cyc = 0; cyc < 14000; cyc++) begin
            feeding = (cyc < 10000);
            n_checks++;
            if (omux_req_o !== m_busy || fill_o !== 5'(m_q.size()) || rec_full_o !== (m_q.size() == DEPTH) ||
                lost_o !== 16'(m_lost)) begin
                n_fail++;
                $display("FAIL random_state_c%0d: req=%b fill=%0d full=%b lost=%0d, expected %b %0d %b %0d",
                         cyc, omux_req_o, fill_o, rec_full_o, lost_o, m_busy, m_q.size(), m_q.size() == DEPTH, m_lost);
            end
            if (m_busy) begin
                n_checks++;
                if (omux_data_o !== byte_of(m_hold, m_idx)) begin
                    n_fail++;
                    $display("FAIL random_data_c%0d: data=%h, expected %h", cyc, omux_data_o, byte_of(m_hold, m_idx));
                end
            end
            if (!feeding && !m_busy && m_q.size() == 0) break;
            if (n_fail - fail0 > 20) break;

            // Alternate bursty and sparse phases so the FIFO both overflows and drains.
            if (!feeding)                   wr = 1'b0;
            else if ((cyc / 1000) % 2 == 0) wr = ($urandom_range(0, 2) == 0);
            else                            wr = ($urandom_range(0, 39) == 0);
            t64 = {$urandom, $urandom};
            r   = t64[47:0];
            s   = 1'b0;
            if (m_busy) begin
                if (gap == 0) begin
                    s   = 1'b1;
                    gap = $urandom_range(0, 4);
                end else begin
                    gap--;
                end
            end
            if (s) begin
                rx = {rx[39:0], omux_data_o};
                rx_n++;
                if (rx_n == REC_BYTES) begin
                    n_checks++;
                    if (rx !== m_hold) begin
                        n_fail++;
                        $display("FAIL random_record%0d: got %h, expected %h", n_rx, rx, m_hold);
                    end
                    rx_n = 0;
                    n_rx++;
                end
            end

            rec_wr = wr;
            rec    = r;
            sel    = s;
            step;
            rec_wr = 1'b0;
            sel    = 1'b0;

            start_size = m_q.size();
            if (!m_busy) begin
                if (start_size > 0) begin
                    m_hold = m_q.pop_front();
                    m_busy = 1'b1;
                    m_idx  = 0;
                end
            end else if (s) begin
                m_idx++;
                if (m_idx == REC_BYTES) m_busy = 1'b0;
            end
            if (wr) begin
                n_wr++;
                if (start_size == DEPTH) begin
                    if (m_lost < 65535) m_lost++;
                end else begin
                    m_q.push_back(r);
                    n_acc++;
                end
            end
        end
        n_checks++;
        if (m_busy || m_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: busy=%b queued=%0d, expected 0 0 within cycle budget", m_busy, m_q.size());
        end
        n_checks++;
        if (int'(lost_o) + n_acc != n_wr) begin
            n_fail++;
            $display("FAIL random_accounting: accepted %0d + lost %0d, expected writes %0d", n_acc, lost_o, n_wr);
        end
        n_checks++;
        if (n_rx != n_acc) begin
            n_fail++;
            $display("FAIL random_received: received %0d records, expected %0d", n_rx, n_acc);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rec      = '0;
        rec_wr   = 1'b0;
        lost_clr = 1'b0;
        sel      = 1'b0;
        test_reset;
        test_single_record;
        test_sel_stall;
        test_full_overflow;
        test_lost_counter;
        test_reset_mid_record;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_record_src.md
# tag_record_src

Buffers fixed-size tag records produced by the timetagger core and serialises them, most significant byte first, as a requester on the host interface's output multiplexer. It sits between the tag generator and one `omux_req_i`/`omux_sel_o`/`omux_data_i` slot of the host interface. Records are requested whole, which lets the register manager's replies interleave only at record boundaries. Records that arrive while the buffer is full are counted, not stalled.

## Interface
- `REC_BYTES`, default 6: bytes per record.
- `DEPTH_LOG2`, default 4: record FIFO depth is 2^DEPTH_LOG2.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `rec_i`  in  8*REC_BYTES  record data, sampled when `rec_wr_i` is high.
- `rec_wr_i`  in  1  single-cycle write strobe; no back-pressure.
- `rec_full_o`  out  1  FIFO full; a write in this cycle is dropped.
- `fill_o`  out  DEPTH_LOG2+1  records held in the FIFO, excluding the record being sent.
- `lost_o`  out  16  saturating count of dropped records.
- `lost_clr_i`  in  1  clears `lost_o`.
- `omux_req_o`  out  1  request to the output mux.
- `omux_sel_i`  in  1  grant from the output mux. This source drives data while it is high.
- `omux_data_o`  out  8  current byte. It is valid whenever `omux_req_o` is high.

## Operation
- The FIFO holds 2^DEPTH_LOG2 records using binary read/write pointers that wrap naturally. A registered count drives `fill_o` and `rec_full_o` (full is count == 2^DEPTH_LOG2).
- A write with `rec_wr_i` high and the count not full stores `rec_i`.
- A write with `rec_wr_i` high while full is dropped, and `lost_o` increments, saturating at 0xFFFF.
- The full decision uses the count at the start of the cycle. A pop in the same cycle does not rescue the write.
- `lost_clr_i` takes priority over the increment, except when both happen in the same cycle: then `lost_o` becomes 1.
- The sender has two states:
  - IDLE: the hold register is empty. If the FIFO is non-empty, pop one record into the hold register, set the byte index to 0, and go to SEND.
  - SEND: `omux_req_o` = 1 and `omux_data_o` = byte (REC_BYTES-1-idx) of the hold register, so byte REC_BYTES-1 [MSB] goes first.
- A byte is consumed at each rising edge where `omux_sel_i` and `omux_req_o` are both high. On consumption, idx increments.
- When the consumed byte was idx == REC_BYTES-1, go to IDLE. `omux_req_o` drops next cycle even if the FIFO is non-empty.
- Each byte is consumed exactly once however long `omux_sel_i` stays low. The mux asserts sel for one cycle per byte and waits for the FT2232 ack between bytes; the source does not see the ack.
- A simultaneous push and pop in one cycle leaves the count unchanged.
- Reset behaviour:
  - FIFO emptied, pointers set to 0, hold register and idx set to 0, state IDLE, `lost_o` = 0.
  - A record partially sent at reset is abandoned. The host sees a truncated record; host software resynchronises.
- Reset values of outputs: `omux_req_o` 0, `omux_data_o` 0x00, `rec_full_o` 0, `fill_o` 0, `lost_o` 0.

## Timing
- Write at edge E0: `fill_o` = 1 after E0. Pop at E1: `fill_o` = 0 and `omux_req_o` = 1 after E1, so there are 2 cycles from strobe to request.
- `omux_data_o` is a combinational select from registers. It is stable throughout SEND until the consuming edge.
- Between consecutive records, `omux_req_o` is low for exactly 1 cycle. This makes the mux return to idle and re-arbitrate, which gives the register manager, at priority index 0, access between records.
- Per-record cost: REC_BYTES grants plus 1 gap cycle, plus the mux/FT2232 ack latency per byte.
- Registered outputs: `fill_o`, `rec_full_o`, `lost_o`, `omux_req_o`. The only combinational path is `omux_data_o` (a mux from hold/idx).

## Test plan
- Single record 0x0A0B0C0D0E0F, with a mux model granting one cycle per byte and a 3-cycle ack gap -> bytes 0A,0B,0C,0D,0E,0F in order. Request is high 2 cycles after the strobe and low the cycle after the 0F grant.
- Sel held low for 20 cycles mid-record after the byte 0C grant -> `omux_data_o` stays 0x0D and no byte is skipped or repeated.
- 17 back-to-back writes with DEPTH_LOG2 = 4 and no grants -> the first is popped, 16 are buffered, `rec_full_o` = 1, and further writes increment `lost_o`. Verify `fill_o` = 16 and that 16 records drain in order with a 1-cycle request gap between them.
- Write on the same cycle as `lost_clr_i` with `lost_o` = 5 while full -> `lost_o` = 1. With `lost_o` at 0xFFFF and a further drop -> it stays 0xFFFF.
- Reset asserted after 3 of 6 bytes with 2 records queued -> the next cycle has req 0, fill 0, data 0x00. A new record after reset is sent complete from its MSB.
- Random writes and random grant delays over 10k cycles -> a scoreboard matches every accepted record byte-for-byte, and accepted plus `lost_o` equals the number of writes.
